// File: rtl/mem_tg_axi_gen.sv
// AXI4 memory traffic generator/checker: write, read-check and write-then-verify over one channel.
// Optional `MEM_TG_ERR_INJECT_EN adds an err_inject port that corrupts bit 0 of the next written beat.
module mem_tg_axi_gen #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 512,
  parameter int ID_W            = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 32,
  parameter int TIMEOUT_CYC     = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [1:0]          cfg_mode,
  input  logic [ADDR_W-1:0]   cfg_base_addr,
  input  logic [CNT_W-1:0]    cfg_num_bursts,
  input  logic [7:0]          cfg_burst_len,
  input  logic [31:0]         cfg_seed,
`ifdef MEM_TG_ERR_INJECT_EN
  input  logic                err_inject,
`endif
  output logic                busy,
  output logic                pass,
  output logic                fail,
  output logic                timeout,
  output logic [63:0]         clock_count,
  output logic [CNT_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic                awuser,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic                aruser,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready
);

  localparam int SZ    = $clog2(DATA_W / 8);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {IDLE, WR, WR_DRAIN, RD, DONE} state_t;
  state_t state;

  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q, stride_q, r_addr;
  logic [CNT_W-1:0]  num_q, aw_cnt, w_burst, b_cnt, ar_cnt, r_burst;
  logic [7:0]        len_q, w_beat, r_beat;
  logic [31:0]       seed_q, w_j, r_jbase;
  logic [OUT_W-1:0]  out_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              err_seen;
  logic              inj_bit;

  function automatic logic [DATA_W-1:0] pat(input logic [31:0] v);
    return {(DATA_W/32){v}};
  endfunction

  assign awid    = '0;
  assign awlen   = len_q;
  assign awsize  = 3'(SZ);
  assign awburst = 2'b01;
  assign awlock  = 1'b0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awuser  = 1'b0;
  assign wstrb   = '1;
  assign arid    = '0;
  assign arlen   = len_q;
  assign arsize  = 3'(SZ);
  assign arburst = 2'b01;
  assign arlock  = 1'b0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign aruser  = 1'b0;

  logic unused_ids;
  assign unused_ids = ^{bid, rid};

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

  logic [ADDR_W-1:0] stride_in;
  assign stride_in = (ADDR_W'(cfg_burst_len) + ADDR_W'(1)) << SZ;

  // A misplaced or missing rlast is one error for that beat, not a data error on top.
  logic [DATA_W-1:0] r_exp;
  logic              r_bad, b_bad, fail_now;
  assign r_exp    = pat(seed_q + r_jbase + 32'(r_beat));
  assign r_bad    = r_hs && ((rdata != r_exp) || (rresp != 2'b00) || (rlast != (r_beat == len_q)));
  assign b_bad    = b_hs && (bresp != 2'b00);
  assign fail_now = fail || r_bad || b_bad;

  logic [CNT_W-1:0] err_inc, ar_cnt_nxt;
  logic [OUT_W-1:0] out_nxt;
  logic [7:0]       w_beat_nxt;
  logic             w_last_acc, b_done, r_done;
  assign err_inc    = err_count + CNT_W'(err_count != '1);
  assign ar_cnt_nxt = ar_cnt + CNT_W'(ar_hs);
  assign out_nxt    = out_cnt + OUT_W'(ar_hs) - OUT_W'(r_hs && rlast);
  assign w_beat_nxt = wlast ? 8'd0 : w_beat + 8'd1;
  assign w_last_acc = w_hs && wlast && (w_burst == num_q - CNT_W'(1));
  assign b_done     = (b_cnt + CNT_W'(b_hs)) == num_q;
  assign r_done     = r_hs && rlast && (r_burst == num_q - CNT_W'(1));

`ifdef MEM_TG_ERR_INJECT_EN
  logic inj_armed;
  assign inj_bit = inj_armed;
`else
  assign inj_bit = 1'b0;
`endif

  logic [DATA_W-1:0] w_pat_start, w_pat_next;
  assign w_pat_start = pat(cfg_seed) ^ DATA_W'(inj_bit);
  assign w_pat_next  = pat(seed_q + w_j + 32'd1) ^ DATA_W'(inj_bit);

  logic go_wr, w_load;
  assign go_wr  = (state == IDLE || state == DONE) && cfg_start &&
                  (cfg_num_bursts != '0) && (cfg_mode != 2'd1);
  assign w_load = go_wr || (state == WR && w_hs && !w_last_acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode_q <= '0; base_q <= '0; stride_q <= '0; num_q <= '0; len_q <= '0; seed_q <= '0;
      busy <= 1'b0; pass <= 1'b0; fail <= 1'b0; timeout <= 1'b0;
      clock_count <= '0; err_count <= '0; first_err_addr <= '0; err_seen <= 1'b0;
      aw_cnt <= '0; w_burst <= '0; b_cnt <= '0; ar_cnt <= '0; r_burst <= '0;
      w_beat <= '0; r_beat <= '0; w_j <= '0; r_jbase <= '0; r_addr <= '0;
      out_cnt <= '0; to_cnt <= '0;
      awaddr <= '0; awvalid <= 1'b0; wdata <= '0; wlast <= 1'b0; wvalid <= 1'b0;
      bready <= 1'b0; araddr <= '0; arvalid <= 1'b0; rready <= 1'b0;
`ifdef MEM_TG_ERR_INJECT_EN
      inj_armed <= 1'b0;
`endif
    end else begin
      if (busy) begin
        clock_count <= clock_count + 64'd1;
        to_cnt      <= any_hs ? '0 : to_cnt + TO_W'(1);
      end
      if (r_bad || b_bad) begin
        err_count <= err_inc;
        fail      <= 1'b1;
      end
      if (r_bad && !err_seen) begin
        first_err_addr <= r_addr;
        err_seen       <= 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (cfg_start) begin
            mode_q <= cfg_mode; base_q <= cfg_base_addr; stride_q <= stride_in;
            num_q <= cfg_num_bursts; len_q <= cfg_burst_len; seed_q <= cfg_seed;
            pass <= 1'b0; fail <= 1'b0; timeout <= 1'b0;
            clock_count <= '0; err_count <= '0; first_err_addr <= '0; err_seen <= 1'b0;
            aw_cnt <= '0; w_burst <= '0; b_cnt <= '0; ar_cnt <= '0; r_burst <= '0;
            w_beat <= '0; r_beat <= '0; w_j <= '0; r_jbase <= '0; r_addr <= cfg_base_addr;
            out_cnt <= '0; to_cnt <= '0;
            awaddr <= cfg_base_addr; araddr <= cfg_base_addr;
            if (cfg_num_bursts == '0) begin
              state <= DONE;
              pass  <= 1'b1;
            end else if (cfg_mode == 2'd1) begin
              state <= RD; busy <= 1'b1; arvalid <= 1'b1; rready <= 1'b1;
            end else begin
              state <= WR; busy <= 1'b1; awvalid <= 1'b1; wvalid <= 1'b1; bready <= 1'b1;
              wdata <= w_pat_start;
              wlast <= (cfg_burst_len == 8'd0);
            end
          end
        end

        WR, WR_DRAIN: begin
          if (aw_hs) begin
            aw_cnt  <= aw_cnt + CNT_W'(1);
            awaddr  <= awaddr + stride_q;
            awvalid <= (aw_cnt + CNT_W'(1)) != num_q;
          end
          if (b_hs) b_cnt <= b_cnt + CNT_W'(1);
          if (state == WR && w_hs) begin
            w_j <= w_j + 32'd1;
            if (w_last_acc) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              state  <= WR_DRAIN;
            end else begin
              wdata  <= w_pat_next;
              w_beat <= w_beat_nxt;
              wlast  <= (w_beat_nxt == len_q);
              if (wlast) w_burst <= w_burst + CNT_W'(1);
            end
          end
          if (state == WR_DRAIN && b_done) begin
            bready <= 1'b0;
            if (mode_q == 2'd0) begin
              state <= DONE; busy <= 1'b0; pass <= !fail_now;
            end else begin
              state <= RD; arvalid <= 1'b1; rready <= 1'b1; araddr <= base_q;
            end
          end
        end

        RD: begin
          if (ar_hs) begin
            ar_cnt <= ar_cnt_nxt;
            araddr <= araddr + stride_q;
          end
          arvalid <= (ar_cnt_nxt != num_q) && (out_nxt < OUT_W'(MAX_OUTSTANDING));
          out_cnt <= out_nxt;
          if (r_hs) begin
            if (rlast) begin
              r_burst <= r_burst + CNT_W'(1);
              r_beat  <= 8'd0;
              r_jbase <= r_jbase + 32'(len_q) + 32'd1;
              r_addr  <= r_addr + stride_q;
            end else begin
              r_beat <= r_beat + 8'd1;
            end
          end
          if (r_done) begin
            state <= DONE; busy <= 1'b0; pass <= !fail_now;
            arvalid <= 1'b0; rready <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase

      // Timeout abandons everything in flight; later assignments override the state case above.
      if (busy && !any_hs && to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        state <= DONE; busy <= 1'b0; pass <= 1'b0; fail <= 1'b1; timeout <= 1'b1;
        awvalid <= 1'b0; wvalid <= 1'b0; wlast <= 1'b0; bready <= 1'b0;
        arvalid <= 1'b0; rready <= 1'b0;
      end

`ifdef MEM_TG_ERR_INJECT_EN
      if (w_load) inj_armed <= 1'b0;
      if (err_inject) inj_armed <= 1'b1;
`endif
    end
  end

  logic unused_load;
  assign unused_load = w_load;

endmodule

// File: tb/tb_mem_tg_axi_gen.sv
// Directed bench for mem_tg_axi_gen: behavioural AXI slave memory plus address/data scoreboards.
module tb_mem_tg_axi_gen;
  localparam int AW = 32, DW = 512, IDW = 8, MO = 2, CW = 32, TO = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           cfg_start;
  logic [1:0]     cfg_mode;
  logic [AW-1:0]  cfg_base_addr;
  logic [CW-1:0]  cfg_num_bursts;
  logic [7:0]     cfg_burst_len;
  logic [31:0]    cfg_seed;
  logic           busy, pass, fail, timeout;
  logic [63:0]    clock_count;
  logic [CW-1:0]  err_count;
  logic [AW-1:0]  first_err_addr;
  logic [IDW-1:0] awid, bid, arid, rid;
  logic [AW-1:0]  awaddr, araddr;
  logic [7:0]     awlen, arlen;
  logic [2:0]     awsize, awprot, arsize, arprot;
  logic [1:0]     awburst, arburst, bresp, rresp;
  logic [3:0]     awcache, arcache;
  logic           awlock, awuser, awvalid, awready, arlock, aruser, arvalid, arready;
  logic [DW-1:0]  wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic           wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  mem_tg_axi_gen #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IDW), .MAX_OUTSTANDING(MO),
                   .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_base_addr(cfg_base_addr), .cfg_num_bursts(cfg_num_bursts),
    .cfg_burst_len(cfg_burst_len), .cfg_seed(cfg_seed),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout), .clock_count(clock_count),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awuser(awuser),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .aruser(aruser),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [31:0] v);
    return {(DW/32){v}};
  endfunction

  // Scoreboards and slave state
  logic [AW-1:0] exp_aw[$], exp_ar[$];
  logic [DW-1:0] exp_w[$];
  bit            exp_wl[$];
  logic [DW-1:0] mem [logic [31:0]];
  logic [31:0]   aq_a[$], arq_a[$];
  int            aq_l[$], arq_l[$], arq_t[$];
  logic [DW-1:0] wq[$];
  logic [31:0]   ra;
  int pend_b = 0, rbeat = 0, cyc = 0, outst = 0, max_out = 0, rdelay = 0;
  int n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  bit hold_aw = 1'b0;

  always @(negedge clk) begin
    awready = !hold_aw;
    wready  = 1'b1;
    arready = 1'b1;
    bid = '0; rid = '0; bresp = 2'b00; rresp = 2'b00;
    bvalid = (pend_b > 0);
    if (arq_a.size() > 0 && cyc >= arq_t[0]) begin
      ra     = arq_a[0] + 32'(rbeat) * 32'd64;
      rdata  = mem.exists(ra) ? mem[ra] : '0;
      rlast  = (rbeat == arq_l[0]);
      rvalid = 1'b1;
    end else begin
      rdata = '0; rlast = 1'b0; rvalid = 1'b0;
    end
    #3;
    if (awvalid && awready) begin
      if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
      else check("awaddr", awaddr, exp_aw.pop_front());
      aq_a.push_back(awaddr);
      aq_l.push_back(int'(awlen));
    end
    if (wvalid && wready) begin
      n_w++;
      if (exp_w.size() == 0) check("w_unexpected", 1, 0);
      else begin
        check("wdata", wdata, exp_w.pop_front());
        check("wlast", wlast, exp_wl.pop_front());
      end
      wq.push_back(wdata);
    end
    while (aq_a.size() > 0 && wq.size() > aq_l[0]) begin
      for (int b = 0; b <= aq_l[0]; b++) mem[aq_a[0] + 32'(b) * 32'd64] = wq.pop_front();
      void'(aq_a.pop_front());
      void'(aq_l.pop_front());
      pend_b++;
    end
    if (bvalid && bready) begin pend_b--; n_b++; end
    if (arvalid && arready) begin
      n_ar++;
      if (exp_ar.size() == 0) check("ar_unexpected", 1, 0);
      else check("araddr", araddr, exp_ar.pop_front());
      arq_a.push_back(araddr);
      arq_l.push_back(int'(arlen));
      arq_t.push_back(cyc + rdelay);
      outst++;
      if (outst > max_out) max_out = outst;
    end
    if (rvalid && rready) begin
      n_r++;
      if (rlast) begin
        void'(arq_a.pop_front()); void'(arq_l.pop_front()); void'(arq_t.pop_front());
        rbeat = 0;
        outst--;
      end else rbeat++;
    end
    cyc++;
  end

  task automatic run(input logic [1:0] mode, input logic [31:0] base, input logic [31:0] num,
                     input logic [7:0] len, input logic [31:0] seed);
    bit wr, rd;
    logic [31:0] stride;
    wr = (mode != 2'd1);
    rd = (mode != 2'd0);
    stride = (32'(len) + 32'd1) * 32'd64;
    for (int k = 0; k < int'(num); k++) begin
      if (wr) exp_aw.push_back(base + 32'(k) * stride);
      if (rd) exp_ar.push_back(base + 32'(k) * stride);
    end
    if (wr)
      for (int j = 0; j < int'(num) * (int'(len) + 1); j++) begin
        exp_w.push_back(pat(seed + 32'(j)));
        exp_wl.push_back((j % (int'(len) + 1)) == int'(len));
      end
    n_w = 0; n_b = 0; n_ar = 0; n_r = 0; max_out = 0;
    @(negedge clk);
    cfg_mode = mode; cfg_base_addr = base; cfg_num_bursts = num;
    cfg_burst_len = len; cfg_seed = seed; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check(tag, busy, 0);
  endtask

  logic [DW-1:0] tmp;

  initial begin
    cfg_start = 1'b0; cfg_mode = '0; cfg_base_addr = '0; cfg_num_bursts = '0;
    cfg_burst_len = '0; cfg_seed = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_timeout", timeout, 0);
    check("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst_counts", {clock_count, err_count, first_err_addr}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero bursts: immediate pass, no AXI activity
    run(2'd2, 32'h3000, 32'd0, 8'd3, 32'h1);
    check("zero_pass", pass, 1);
    check("zero_busy", busy, 0);
    check("zero_valids", {awvalid, wvalid, arvalid}, 0);
    repeat (3) @(negedge clk);
    check("zero_valids_later", {awvalid, wvalid, arvalid}, 0);
    check("zero_clk_cnt", clock_count, 0);

    // Write-then-verify with an ignored restart while busy
    run(2'd2, 32'h1000, 32'd4, 8'd3, 32'hA5A5_0000);
    check("wv_busy", busy, 1);
    check("wv_awsize", {awsize, awburst, arsize, arburst}, {3'd6, 2'b01, 3'd6, 2'b01});
    repeat (3) @(negedge clk);
    cfg_mode = 2'd1; cfg_base_addr = 32'h9000; cfg_num_bursts = 32'd1; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    wait_done("wv_done");
    check("wv_pass", {pass, fail, timeout}, 3'b100);
    check("wv_err", err_count, 0);
    check("wv_counts", {n_w, n_b, n_ar, n_r}, {32'd16, 32'd4, 32'd4, 32'd16});
    check("wv_clk_pos", clock_count > 0, 1);
    check("wv_sb_empty", exp_aw.size() + exp_ar.size() + exp_w.size(), 0);

    // Read-check against memory with beat 5 corrupted
    for (int k = 0; k < 8; k++) mem[32'h2000 + 32'(k) * 32'd64] = pat(32'h100 + 32'(k));
    tmp = mem[32'h2140];
    tmp[0] = ~tmp[0];
    mem[32'h2140] = tmp;
    run(2'd1, 32'h2000, 32'd8, 8'd0, 32'h100);
    wait_done("rc_done");
    check("rc_flags", {pass, fail, timeout}, 3'b010);
    check("rc_err", err_count, 1);
    check("rc_first_err", first_err_addr, 32'h2140);
    check("rc_counts", {n_ar, n_r}, {32'd8, 32'd8});

    // Delayed R with two-deep outstanding limit
    for (int j = 0; j < 12; j++) mem[32'h4000 + 32'(j) * 32'd64] = pat(32'h777 + 32'(j));
    rdelay = 50;
    run(2'd1, 32'h4000, 32'd6, 8'd1, 32'h777);
    wait_done("dl_done");
    check("dl_pass", {pass, fail, timeout}, 3'b100);
    check("dl_max_out_le", max_out <= MO, 1);
    check("dl_max_out_hit", max_out, MO);
    check("dl_r_beats", n_r, 12);
    rdelay = 0;

    // Address wrap at top of the address space
    run(2'd2, 32'hFFFF_FFC0, 32'd2, 8'd0, 32'h55);
    wait_done("wrap_done");
    check("wrap_pass", {pass, fail, timeout}, 3'b100);
    check("wrap_sb_empty", exp_aw.size() + exp_ar.size() + exp_w.size(), 0);
    check("wrap_mem0", mem.exists(32'h0) ? mem[32'h0] : '0, pat(32'h56));

    // Timeout with AW stalled forever
    hold_aw = 1'b1;
    run(2'd0, 32'h8000, 32'd2, 8'd0, 32'h1);
    wait_done("to_done");
    check("to_flags", {pass, fail, timeout}, 3'b011);
    check("to_valids", {awvalid, wvalid, arvalid}, 0);
    check("to_clk_range", clock_count >= 64'(TO) && clock_count <= 64'(TO + 5), 1);
    repeat (3) @(negedge clk);
    check("to_hold", {busy, timeout, awvalid}, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_tg_axi_gen.md
Name: mem_tg_axi_gen

Overview:
- Parametrised, self-contained AXI4 memory traffic generator and checker for one external memory channel.
- Next generation of the per-channel TG used in the memory-test AFU: native write / read / write-then-verify modes, configurable burst length, outstanding-read depth and data width.
- Adds an error counter, first-error capture and an activity-based timeout.
- Sits between the AFU CSR block (config/status) and the EMIF AXI-MM user port; the top level instantiates one per channel.

Parameters:
- ADDR_W, 32, AXI address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 512, AXI data width; multiple of 32.
- ID_W, 8, AXI ID width; all requests use ID 0.
- MAX_OUTSTANDING, 8, maximum read bursts issued but not fully returned; range 1..64.
- CNT_W, 32, width of num_bursts and the error counter.
- TIMEOUT_CYC, 65536, cycles without any AXI handshake before timeout.

Ports:
- clk  in  1  memory-domain clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  single-cycle pulse; starts a run when idle
- cfg_mode  in  2  0=write, 1=read-check, 2=write-then-verify, 3=reserved (treated as 2)
- cfg_base_addr  in  ADDR_W  start byte address, burst-size aligned
- cfg_num_bursts  in  CNT_W  bursts per phase; 0 means immediate pass
- cfg_burst_len  in  8  AXI awlen/arlen (beats-1)
- cfg_seed  in  32  pattern seed
- busy / pass / fail / timeout  out  1 each  run status
- clock_count  out  64  cycles from start to done
- err_count  out  CNT_W  mismatching beats, saturating
- first_err_addr  out  ADDR_W  burst address of the first mismatch
- AXI master  out/in  standard widths  aw*, w*, b*, ar*, r* channels (awid/arid/awsize/awburst/awlock/awcache/awprot/awuser equivalents included)

Behaviour:
- Reset (async assert, sync deassert expected): FSM=IDLE; all status outputs, counters and every *valid/*ready output are 0.
- States: IDLE, WR, WR_DRAIN, RD, DONE.
- IDLE:
  - cfg_start latches all cfg_* inputs, clears status and counters, sets busy the next cycle.
  - Next state: WR (mode 0/2/3) or RD (mode 1).
  - num_bursts=0: go straight to DONE with pass=1.
- Address of burst k = base + k*(burst_len+1)*(DATA_W/8), truncated to ADDR_W.
- Fixed AXI attributes: awsize/arsize = log2(DATA_W/8), INCR, id 0, cache 0, prot 0, wstrb all-ones.
- Data of global beat j (counted within the phase) = DATA_W/32 copies of (cfg_seed + j) mod 2^32.
- WR:
  - AW and W run independently; W for burst k may precede its AW.
  - wlast on the beat (burst_len) of each burst.
  - AWVALID/WVALID are held with stable payload until ready.
  - Go to WR_DRAIN when the last W is accepted.
- WR_DRAIN: bready=1 constantly. Wait for num_bursts B responses, then:
  - mode 0: DONE.
  - else: RD, with beat index reset to 0.
- bresp != OKAY: increment err_count and set fail.
- RD:
  - Issue AR while issued-minus-completed < MAX_OUTSTANDING; a burst completes on rlast.
  - rready=1 constantly.
  - Compare each R beat with the expected pattern. On mismatch or rresp != OKAY: err_count++ (saturating); first_err_addr captured only on the first error.
  - Last rlast of the phase: DONE.
  - rlast on the wrong beat counts as one error and realigns to the next burst.
- Simultaneous AR issue and rlast in the same cycle: net outstanding count unchanged.
- Timeout counter:
  - Cleared on any handshake; counts only while busy.
  - Reaching TIMEOUT_CYC: timeout=1, fail=1, DONE. Outstanding transactions are abandoned and *valid outputs drop.
- DONE:
  - busy=0; pass = !fail && !timeout.
  - Status holds until the next cfg_start.
  - clock_count increments every busy cycle and freezes in DONE.
- cfg_start while busy is ignored.
- Reset mid-run aborts immediately. Memory-side recovery is the EMIF reset's job.

Optional Feature:
- MEM_TG_ERR_INJECT_EN defined: adds input port err_inject (1 bit). A pulse arms a one-shot flag; the next accepted W beat has bit 0 inverted, then the flag clears. Write-then-verify then reports err_count=1 and fail=1.
- Undefined: the port does not exist and data is never corrupted.

Test Plan:
- Mode 2, base 0x1000, num_bursts 4, len 3, seed 0xA5A50000, ideal slave memory -> 16 W beats, 4 B, 4 AR, 16 R; pass=1, err_count=0, clock_count>0.
- Mode 1 on memory pre-loaded with beat 5 corrupted, len 0, 8 bursts -> fail=1, err_count=1, first_err_addr = base+5*DATA_W/8.
- MAX_OUTSTANDING=2, slave delays R by 50 cycles -> never more than 2 ARs outstanding; pass=1.
- Slave holds awready=0 forever -> timeout=1, fail=1 after TIMEOUT_CYC cycles; awvalid deasserts; busy=0.
- base 0xFFFF_FFC0, DATA_W 512, 2 bursts len 0 -> second address 0x0 (wrap); pass=1.
- num_bursts=0 -> pass=1 one cycle after start, no AXI valid asserted; second cfg_start while busy has no effect.
